// File: rtl/rf16b_wb_sched.sv
// rtl/rf16b_wb_sched.sv - write-back scheduler sharing one register-file write port between ALU and load returns
module rf16b_wb_sched #(
    parameter int WIDTH      = 16,
    parameter int NREGISTERS = 4,
    parameter int LBUF_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [$clog2(NREGISTERS)-1:0] alu_rd,
    input  logic [WIDTH-1:0]              alu_data,
    output logic                          alu_ready,
    input  logic                          ld_issue,
    input  logic [$clog2(NREGISTERS)-1:0] ld_issue_rd,
    input  logic                          ld_valid,
    input  logic [$clog2(NREGISTERS)-1:0] ld_rd,
    input  logic [WIDTH-1:0]              ld_data,
    output logic                          ld_ready,
    input  logic [$clog2(NREGISTERS)-1:0] ra,
    input  logic [$clog2(NREGISTERS)-1:0] rb,
    output logic                          hazard,
    output logic [NREGISTERS-1:0]         pend,
    output logic [$clog2(NREGISTERS)-1:0] rf_rd,
    output logic [WIDTH-1:0]              rf_data,
    output logic                          rf_en
);

    localparam int RW = $clog2(NREGISTERS);
    localparam int PW = $clog2(LBUF_DEPTH);
    localparam int CW = $clog2(LBUF_DEPTH + 1);

    // Load-return FIFO: each entry carries {destination, data}
    logic [RW+WIDTH-1:0] mem [LBUF_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [RW+WIDTH-1:0] head;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    logic                alu_win;
    logic                fifo_win;
    logic                rf_src_ld;
    logic [NREGISTERS-1:0] set_mask;
    logic [NREGISTERS-1:0] clr_mask;

    assign full     = (count == CW'(LBUF_DEPTH));
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    // A full FIFO refuses a push even if it pops this cycle, keeping the guard simple
    assign ld_ready = !full;
    assign push     = ld_valid && ld_ready;
    assign pop      = fifo_win;

    assign hazard   = pend[ra] | pend[rb];

    // Arbitration: ALU has priority unless the FIFO is full, then the head must drain
    always_comb begin
        alu_ready = 1'b1;
        alu_win   = 1'b0;
        fifo_win  = 1'b0;
        if (full && !empty) begin
            alu_ready = 1'b0;
            fifo_win  = 1'b1;
        end else if (alu_valid) begin
            alu_win = 1'b1;
        end else if (!empty) begin
            fifo_win = 1'b1;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count and pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ld_rd, ld_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port; index and data hold when nobody wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_en     <= 1'b0;
            rf_rd     <= '0;
            rf_data   <= '0;
            rf_src_ld <= 1'b0;
        end else begin
            rf_en     <= alu_win | fifo_win;
            rf_src_ld <= fifo_win;
            if (alu_win) begin
                rf_rd   <= alu_rd;
                rf_data <= alu_data;
            end else if (fifo_win) begin
                rf_rd   <= head[RW+WIDTH-1:WIDTH];
                rf_data <= head[WIDTH-1:0];
            end
        end
    end

    // Pending bits clear when a load write commits, and a new issue to the same register wins
    assign clr_mask = (rf_en && rf_src_ld) ? (NREGISTERS'(1) << rf_rd) : '0;
    assign set_mask = ld_issue ? (NREGISTERS'(1) << ld_issue_rd) : '0;

    // Scoreboard update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: tb/tb_rf16b_wb_sched.sv
// tb/tb_rf16b_wb_sched.sv - self-checking bench for rf16b_wb_sched
module tb_rf16b_wb_sched;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [1:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [1:0]  ld_issue_rd;
    logic        ld_valid;
    logic [1:0]  ld_rd;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic        hazard;
    logic [3:0]  pend;
    logic [1:0]  rf_rd;
    logic [15:0] rf_data;
    logic        rf_en;

    int tests = 0;
    int fails = 0;

    rf16b_wb_sched #(.WIDTH(16), .NREGISTERS(4), .LBUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .ra(ra), .rb(rb), .hazard(hazard), .pend(pend),
        .rf_rd(rf_rd), .rf_data(rf_data), .rf_en(rf_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;  logic [1:0] ard; logic [15:0] ad;
        logic        li;  logic [1:0] lir;
        logic        lv;  logic [1:0] lrd; logic [15:0] ld;
        logic [1:0]  ra;  logic [1:0] rb;
        logic        e_ar; logic e_lr; logic e_hz; logic [3:0] e_pend;
        logic        e_en; logic [1:0] e_rd; logic [15:0] e_data;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(
        input logic av, input logic [1:0] ard, input logic [15:0] ad,
        input logic li, input logic [1:0] lir,
        input logic lv, input logic [1:0] lrd, input logic [15:0] ld,
        input logic [1:0] a, input logic [1:0] b,
        input logic ear, input logic elr, input logic ehz, input logic [3:0] ep,
        input logic een, input logic [1:0] erd, input logic [15:0] ed);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.li = li; v.lir = lir;
        v.lv = lv; v.lrd = lrd; v.ld = ld; v.ra = a; v.rb = b;
        v.e_ar = ear; v.e_lr = elr; v.e_hz = ehz; v.e_pend = ep;
        v.e_en = een; v.e_rd = erd; v.e_data = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [1:0] ard, input logic [15:0] ad,
                         input logic li, input logic [1:0] lir,
                         input logic lv, input logic [1:0] lrd, input logic [15:0] ld,
                         input logic [1:0] a, input logic [1:0] b);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_issue = li; ld_issue_rd = lir;
        ld_valid = lv; ld_rd = lrd; ld_data = ld;
        ra = a; rb = b;
    endtask

    // Reference model: queue of returned loads, pending set, registered write port
    logic [17:0] m_q [$];
    logic [3:0]  m_pend;
    logic        m_en;
    logic        m_src;
    logic [1:0]  m_rd;
    logic [15:0] m_data;
    logic [15:0] m_rf [4];
    logic [15:0] dut_rf [4];
    int          dut_writes;
    int          accepted;

    task automatic model_reset();
        m_q.delete();
        m_pend = '0; m_en = 1'b0; m_src = 1'b0; m_rd = '0; m_data = '0;
    endtask

    task automatic model_check();
        logic m_full;
        m_full = (m_q.size() == 2);
        chk("m_alu_ready", alu_ready, !m_full);
        chk("m_ld_ready", ld_ready, !m_full);
        chk("m_hazard", hazard, m_pend[ra] | m_pend[rb]);
        chk("m_pend", pend, m_pend);
        chk("m_rf_en", rf_en, m_en);
        chk("m_rf_rd", rf_rd, m_rd);
        chk("m_rf_data", rf_data, m_data);
        if (rf_en) begin
            dut_rf[rf_rd] = rf_data;
            dut_writes++;
        end
    endtask

    task automatic model_step();
        logic       m_full;
        logic       take_ld;
        logic [3:0] np;
        m_full = (m_q.size() == 2);
        if (m_en) m_rf[m_rd] = m_data;
        np = m_pend;
        if (m_en && m_src) np[m_rd] = 1'b0;
        if (ld_issue) np[ld_issue_rd] = 1'b1;
        m_pend = np;
        take_ld = m_full || (!alu_valid && m_q.size() > 0);
        if (alu_valid && !m_full) accepted++;
        if (take_ld) begin
            m_en = 1'b1; m_src = 1'b1;
            m_rd = m_q[0][17:16]; m_data = m_q[0][15:0];
            void'(m_q.pop_front());
        end else if (alu_valid) begin
            m_en = 1'b1; m_src = 1'b0; m_rd = alu_rd; m_data = alu_data;
        end else begin
            m_en = 1'b0; m_src = 1'b0;
        end
        if (ld_valid && !m_full) begin
            m_q.push_back({ld_rd, ld_data});
            accepted++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0]  = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 0,0, 1,1,0,4'h0, 0,0,16'h0000);
        vecs[1]  = mk(1,2,16'h1234, 0,0, 0,0,16'h0000, 0,0, 1,1,0,4'h0, 0,0,16'h0000);
        vecs[2]  = mk(0,0,16'h0000, 1,1, 0,0,16'h0000, 1,0, 1,1,0,4'h0, 1,2,16'h1234);
        vecs[3]  = mk(0,0,16'h0000, 0,0, 1,1,16'hBEEF, 1,0, 1,1,1,4'h2, 0,2,16'h1234);
        vecs[4]  = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 1,0, 1,1,1,4'h2, 0,2,16'h1234);
        vecs[5]  = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 1,0, 1,1,1,4'h2, 1,1,16'hBEEF);
        vecs[6]  = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 1,0, 1,1,0,4'h0, 0,1,16'hBEEF);
        vecs[7]  = mk(1,0,16'h00A0, 1,2, 1,2,16'h0001, 0,0, 1,1,0,4'h0, 0,1,16'hBEEF);
        vecs[8]  = mk(1,0,16'h00A1, 1,3, 1,3,16'h0002, 0,0, 1,1,0,4'h4, 1,0,16'h00A0);
        vecs[9]  = mk(1,0,16'h00A2, 0,0, 1,1,16'h0003, 0,0, 0,0,0,4'hC, 1,0,16'h00A1);
        vecs[10] = mk(1,0,16'h00A2, 0,0, 0,0,16'h0000, 0,0, 1,1,0,4'hC, 1,2,16'h0001);
        vecs[11] = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 0,0, 1,1,0,4'h8, 1,0,16'h00A2);
        vecs[12] = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 0,0, 1,1,0,4'h8, 1,3,16'h0002);
        vecs[13] = mk(0,0,16'h0000, 1,3, 0,0,16'h0000, 3,0, 1,1,0,4'h0, 0,3,16'h0002);
        vecs[14] = mk(0,0,16'h0000, 0,0, 1,3,16'h5555, 3,0, 1,1,1,4'h8, 0,3,16'h0002);
        vecs[15] = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 3,0, 1,1,1,4'h8, 0,3,16'h0002);
        vecs[16] = mk(0,0,16'h0000, 1,3, 0,0,16'h0000, 3,0, 1,1,1,4'h8, 1,3,16'h5555);
        vecs[17] = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 3,0, 1,1,1,4'h8, 0,3,16'h5555);

        #2 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].li, vecs[i].lir,
                  vecs[i].lv, vecs[i].lrd, vecs[i].ld, vecs[i].ra, vecs[i].rb);
            #4;
            chk($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
            chk($sformatf("v%0d_ld_ready", i), ld_ready, vecs[i].e_lr);
            chk($sformatf("v%0d_hazard", i), hazard, vecs[i].e_hz);
            chk($sformatf("v%0d_pend", i), pend, vecs[i].e_pend);
            chk($sformatf("v%0d_rf_en", i), rf_en, vecs[i].e_en);
            chk($sformatf("v%0d_rf_rd", i), rf_rd, vecs[i].e_rd);
            chk($sformatf("v%0d_rf_data", i), rf_data, vecs[i].e_data);
            @(posedge clk); #1;
        end

        // Fill the FIFO behind ALU traffic, then reset asynchronously mid-cycle
        drive(1, 1, 16'h0F0F, 1, 2, 1, 0, 16'h1111, 0, 0);
        @(posedge clk); #1;
        drive(1, 1, 16'h0F0F, 0, 0, 1, 1, 16'h2222, 0, 0);
        @(posedge clk); #1;
        drive(1, 1, 16'h0F0F, 0, 0, 0, 0, 16'h0000, 2, 3);
        #1;
        chk("pre_rst_ld_ready", ld_ready, 1'b0);
        chk("pre_rst_alu_ready", alu_ready, 1'b0);
        chk("pre_rst_rf_en", rf_en, 1'b1);
        chk("pre_rst_hazard", hazard, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rst_rf_en", rf_en, 1'b0);
        chk("rst_pend", pend, 4'h0);
        chk("rst_ld_ready", ld_ready, 1'b1);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_rf_rd", rf_rd, 2'd0);
        chk("rst_rf_data", rf_data, 16'h0000);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Randomized mixed traffic against the reference model, then drain
        model_reset();
        for (int r = 0; r < 4; r++) begin
            m_rf[r] = '0;
            dut_rf[r] = '0;
        end
        dut_writes = 0;
        accepted = 0;
        for (int c = 0; c < 86; c++) begin
            if (c < 80) begin
                drive(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom),
                      1'($urandom_range(0, 3) == 0), 2'($urandom),
                      1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom),
                      2'($urandom), 2'($urandom));
            end else begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 2'($urandom), 2'($urandom));
            end
            #4;
            model_check();
            model_step();
            @(posedge clk); #1;
        end
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("regfile_r%0d", r), dut_rf[r], m_rf[r]);
        end
        chk("write_count", dut_writes, accepted);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf16b_wb_sched.md
# rf16b_wb_sched

Write-back scheduler for the 4 x 16-bit register file. It shares the register file's single write port between the ALU result path and the memory-load return path. Load returns are buffered in a small FIFO. A per-register scoreboard raises a hazard flag whenever a read operand still waits on an outstanding load. The block sits between execute/memory and the register file, and drives the file's rd/data/en write inputs.

## Interface
- WIDTH, 16, data width
- NREGISTERS, 4, register count; register index width is 2
- LBUF_DEPTH, 2, load-return FIFO depth (power of two, at least 2)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_rd  in  2  ALU destination register
- alu_data  in  16  ALU result
- alu_ready  out  1  ALU result accepted this cycle when alu_valid & alu_ready
- ld_issue  in  1  load issued to memory; marks ld_issue_rd pending
- ld_issue_rd  in  2  destination of the issued load
- ld_valid  in  1  load data returned
- ld_rd  in  2  load destination
- ld_data  in  16  load data
- ld_ready  out  1  load return accepted when ld_valid & ld_ready
- ra, rb  in  2 each  operand indices checked for hazards
- hazard  out  1  pend[ra] | pend[rb]
- pend  out  4  scoreboard, one bit per register
- rf_rd  out  2  register-file write index (registered)
- rf_data  out  16  register-file write data (registered)
- rf_en  out  1  register-file write enable (registered)

## Operation
- Reset (async, high):
  - FIFO empty; count = 0.
  - pend = 0.
  - rf_en = 0, rf_rd = 0, rf_data = 0.
  - Internal rf_src_ld = 0.
- Load FIFO:
  - Push on ld_valid & ld_ready.
  - ld_ready = (count != LBUF_DEPTH). A full FIFO refuses a push even when a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- Write-port arbitration, evaluated each cycle. The winner is registered onto rf_* at the edge:
  - FIFO full and non-empty: FIFO head wins, and alu_ready = 0 (starvation guard).
  - Otherwise ALU has priority and alu_ready = 1. If alu_valid, the ALU wins; if not and the FIFO is non-empty, the FIFO head pops.
  - If nothing wins, rf_en <= 0. rf_rd and rf_data hold their last values.
  - rf_src_ld <= 1 only when the FIFO won.
- Scoreboard:
  - Set: ld_issue sets pend[ld_issue_rd].
  - Clear: when rf_en & rf_src_ld, pend[rf_rd] clears at the same edge the register file samples the write.
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes never touch pend. An ALU write-after-write to a pending register is allowed; the later load overwrites it.
- hazard is combinational from pend, ra and rb.
- A load return whose destination is not pending is still written; there is no error.

## Timing
- ALU path: accepted at edge N; rf_en = 1 during cycle N..N+1; register file updated at edge N+1.
- Load path, minimum latency: pushed at edge N, popped at edge N+1 (ALU idle), register file written at edge N+2. pend bit clears at edge N+2, so hazard is low from cycle N+2 onward.
- Under continuous ALU traffic, a load is delayed until the FIFO fills. Worst-case wait is LBUF_DEPTH accepted returns.
- Throughput: one register-file write per cycle.
- Reset asserted mid-operation discards FIFO contents and pending bits immediately. rf_en drops without waiting for a clock edge.

## Test plan
- Reset: assert rst mid-traffic -> rf_en = 0, pend = 0, ld_ready = 1, and alu_ready = 1 immediately.
- ALU write: alu_valid = 1, alu_rd = 2, alu_data = 0x1234 for 1 cycle -> next cycle rf_en = 1, rf_rd = 2, rf_data = 0x1234; the cycle after, rf_en = 0.
- Load with hazard: ld_issue_rd = 1, ra = 1 -> hazard = 1 the next cycle. Then ld_valid with ld_rd = 1, ld_data = 0xBEEF -> rf write of 0xBEEF two cycles after the push; pend[1] and hazard = 0 after that write edge.
- Starvation guard: alu_valid held high, push loads 0x0001 and 0x0002 -> FIFO full, ld_ready = 0 and alu_ready = 0. FIFO drains 0x0001 then 0x0002 in order, and ALU writes resume once count < 2.
- Set/clear collision: load to r3 commits on the same edge that ld_issue targets r3 -> pend[3] stays 1.
- Back-to-back mix: alternate ALU and load results over 20 cycles with random data -> register-file model matches expected contents, and the write count equals accepted transfers.
